// File: rtl/ocx_dlx_rx_gbx.sv
// ocx_dlx_rx_gbx - receive gearbox: block lock, header classification,
// EDPL parity checking and registered forwarding to the DLX rx framer.
//
// Optional feature macro: OCX_DLX_RX_EDPL_EN
//   defined   : EDPL tracking/check/counter present, 00/11 headers valid
//               when edpl_ena=1.
//   undefined : edpl outputs tied to 0, edpl_ena ignored, 00/11 invalid.
//
// Ports
//   dlx_clk, dlx_reset_n        clock, async active-low reset
//   phy_dlx_rx_valid/header/data block from the PHY (valid low = pause)
//   edpl_ena                    far end uses EDPL header encoding
//   dlx_phy_rx_slip             one-cycle bit-slip request
//   gb_rx_locked                block lock achieved
//   gb_rx_valid/ctl/data        forwarded block, one cycle after input
//   gb_rx_edpl_err/edpl_cnt     parity mismatch pulse, saturating count
//
// state  | meaning
// HUNT   | counting consecutive valid headers toward lock
// SLIP   | slip issued, ignoring input for SLIP_WAIT cycles
// LOCKED | forwarding; counting bad headers per window
module ocx_dlx_rx_gbx #(
   parameter int LOCK_GOOD = 32,
   parameter int BAD_LIMIT = 8,
   parameter int WINDOW    = 64,
   parameter int SLIP_WAIT = 16
) (
   input  logic        dlx_clk,
   input  logic        dlx_reset_n,
   input  logic        phy_dlx_rx_valid,
   input  logic [1:0]  phy_dlx_rx_header,
   input  logic [63:0] phy_dlx_rx_data,
   input  logic        edpl_ena,
   output logic        dlx_phy_rx_slip,
   output logic        gb_rx_locked,
   output logic        gb_rx_valid,
   output logic        gb_rx_ctl,
   output logic [63:0] gb_rx_data,
   output logic        gb_rx_edpl_err,
   output logic [7:0]  gb_rx_edpl_cnt
);

   localparam int GW = $clog2(LOCK_GOOD + 1);
   localparam int SW = $clog2(SLIP_WAIT + 1);
   localparam int WW = $clog2(WINDOW + 1);
   localparam int BW = $clog2(BAD_LIMIT + 1);

   typedef enum logic [1:0] {HUNT = 2'd0, SLIP = 2'd1, LOCKED = 2'd2} state_t;

   state_t        state;
   logic [GW-1:0] good_cnt;
   logic [SW-1:0] slip_tmr;
   logic [WW-1:0] win_cnt;
   logic [BW-1:0] bad_cnt;
   logic          hdr_ctl, hdr_odd, hdr_ok, edpl_on, lock_now, fwd;

`ifdef OCX_DLX_RX_EDPL_EN
   assign edpl_on = edpl_ena;
`else
   logic edpl_unused;
   assign edpl_unused = edpl_ena;
   assign edpl_on     = 1'b0;
`endif

   assign hdr_ctl  = (phy_dlx_rx_header == 2'b10);
   assign hdr_odd  = (phy_dlx_rx_header[1] == phy_dlx_rx_header[0]);
   assign hdr_ok   = (phy_dlx_rx_header == 2'b01) || hdr_ctl || (hdr_odd && edpl_on);
   // the block completing lock is itself the first one forwarded
   assign lock_now = (state == HUNT) && (good_cnt == GW'(LOCK_GOOD - 1));
   assign fwd      = phy_dlx_rx_valid && hdr_ok && ((state == LOCKED) || lock_now);

   assign gb_rx_locked = (state == LOCKED);

   always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         state           <= HUNT;
         good_cnt        <= '0;
         slip_tmr        <= '0;
         win_cnt         <= '0;
         bad_cnt         <= '0;
         dlx_phy_rx_slip <= 1'b0;
      end else begin
         dlx_phy_rx_slip <= 1'b0;
         case (state)
            HUNT: begin
               if (phy_dlx_rx_valid) begin
                  if (!hdr_ok) begin
                     good_cnt        <= '0;
                     slip_tmr        <= SW'(SLIP_WAIT - 1);
                     dlx_phy_rx_slip <= 1'b1;
                     state           <= SLIP;
                  end else if (lock_now) begin
                     good_cnt <= '0;
                     win_cnt  <= '0;
                     bad_cnt  <= '0;
                     state    <= LOCKED;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
            end
            SLIP: begin
               // wait runs on every clock, paused or not
               if (slip_tmr == '0) state <= HUNT;
               else                slip_tmr <= slip_tmr - 1'b1;
            end
            LOCKED: begin
               if (phy_dlx_rx_valid) begin
                  if (!hdr_ok && (bad_cnt == BW'(BAD_LIMIT - 1))) begin
                     // loss of lock wins over a coincident window wrap
                     good_cnt <= '0;
                     win_cnt  <= '0;
                     bad_cnt  <= '0;
                     state    <= HUNT;
                  end else if (win_cnt == WW'(WINDOW - 1)) begin
                     win_cnt <= '0;
                     bad_cnt <= '0;
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                     if (!hdr_ok) bad_cnt <= bad_cnt + 1'b1;
                  end
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         gb_rx_valid <= 1'b0;
         gb_rx_ctl   <= 1'b0;
         gb_rx_data  <= '0;
      end else begin
         gb_rx_valid <= fwd;
         if (fwd) begin
            gb_rx_ctl  <= hdr_ctl;
            gb_rx_data <= phy_dlx_rx_data;
         end
      end
   end

`ifdef OCX_DLX_RX_EDPL_EN
   // prev_odd: parity of last forwarded data block; hist_vld: a data block
   // has been seen since lock/control; phase_11: next odd header is 11
   logic       prev_odd, hist_vld, phase_11, err_q, chk, mism;
   logic [7:0] err_cnt;

   assign chk  = fwd && !hdr_ctl && edpl_ena && hist_vld;
   assign mism = chk && (prev_odd ? !(hdr_odd && (phy_dlx_rx_header[0] == phase_11))
                                  : (phy_dlx_rx_header != 2'b01));

   always_ff @(posedge dlx_clk or negedge dlx_reset_n) begin
      if (!dlx_reset_n) begin
         prev_odd <= 1'b0;
         hist_vld <= 1'b0;
         phase_11 <= 1'b0;
         err_q    <= 1'b0;
         err_cnt  <= '0;
      end else begin
         err_q <= mism;
         if (mism && (err_cnt != 8'hff)) err_cnt <= err_cnt + 1'b1;
         if (!fwd) begin
            if (state != LOCKED) begin
               prev_odd <= 1'b0;
               hist_vld <= 1'b0;
               phase_11 <= 1'b0;
            end else if (!edpl_ena) begin
               prev_odd <= 1'b0;
            end
         end else if (hdr_ctl) begin
            hist_vld <= 1'b0;
         end else begin
            hist_vld <= 1'b1;
            prev_odd <= edpl_ena && (^phy_dlx_rx_data);
            if (chk && prev_odd) phase_11 <= ~phase_11;
         end
      end
   end

   assign gb_rx_edpl_err = err_q;
   assign gb_rx_edpl_cnt = err_cnt;
`else
   assign gb_rx_edpl_err = 1'b0;
   assign gb_rx_edpl_cnt = 8'h00;
`endif

endmodule
